// File: rtl/self_sync_descrambler.sv
// Purpose: multiplicative (self-synchronizing) descrambler, out = in ^ parity(history & TAPS), with lock flag.
// Latency: one cycle; a bit accepted at edge N is presented on the registered output after edge N.
// Backpressure: in_ready = !flush && (!out_valid || out_ready); one output register, no skid buffer.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset (highest priority)
//   flush          synchronous clear of history, fill count, lock and any pending output beat
//   in_bit/in_valid/in_ready     scrambled bit stream, valid/ready handshake
//   out_bit/out_valid/out_ready  descrambled bit stream, valid/ready handshake
//   out_locked     qualifies out_bit: it was derived from ORDER genuine history bits
//
// ORDER may range from 2 to 32. TAPS bit k set means a term at delay k+1
// (default x^7 + x^6 + 1).
module self_sync_descrambler #(
  parameter int unsigned      ORDER = 7,
  parameter logic [ORDER-1:0] TAPS  = 7'b1100000
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_bit,
  input  logic in_valid,
  output logic in_ready,
  output logic out_bit,
  output logic out_valid,
  input  logic out_ready,
  output logic out_locked
);

  // Fill counter only needs to reach ORDER and then saturate.
  localparam int unsigned    CW       = $clog2(ORDER + 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(ORDER);
  localparam logic [CW-1:0]  ONE_CNT  = CW'(1);

  // State
  logic [ORDER-1:0] sr_q, sr_d;               // sr_q[0] = most recent accepted scrambled bit
  logic [CW-1:0]    fill_cnt_q, fill_cnt_d;   // genuine history bits seen since reset/flush
  logic             out_bit_q, out_bit_d;
  logic             out_valid_q, out_valid_d;
  logic             out_locked_q, out_locked_d;

  // Combinational helpers
  logic             accept;
  logic             descr_bit;
  logic             hist_full;

  // The output register may be refilled in the same cycle it drains, so a
  // ready downstream gives full throughput with no bubbles. Flush blocks the
  // input so the beat presented during a flush never enters the history.
  assign in_ready  = !flush && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;

  // Feed-through descrambling: the history holds received (scrambled) bits,
  // so a channel error leaves the register after ORDER shifts and cannot
  // corrupt the state permanently.
  assign descr_bit = in_bit ^ (^(sr_q & TAPS));

  // Lock is judged on the history that produces this beat, i.e. before the
  // current bit is shifted in: beat ORDER+1 is the first locked one.
  assign hist_full = (fill_cnt_q == FULL_CNT);

  always_comb begin
    sr_d         = sr_q;
    fill_cnt_d   = fill_cnt_q;
    out_bit_d    = out_bit_q;
    out_valid_d  = out_valid_q;
    out_locked_d = out_locked_q;

    if (flush) begin
      // Discard history and any pending output beat; out_bit keeps its last
      // value but is no longer qualified by out_valid.
      sr_d         = '0;
      fill_cnt_d   = '0;
      out_valid_d  = 1'b0;
      out_locked_d = 1'b0;
    end else if (accept) begin
      // New beat replaces the old one, whether or not the old one was taken
      // this cycle (in_ready guarantees it was, if it was valid).
      out_bit_d    = descr_bit;
      out_valid_d  = 1'b1;
      out_locked_d = hist_full;
      sr_d         = {sr_q[ORDER-2:0], in_bit};
      if (!hist_full) begin
        fill_cnt_d = fill_cnt_q + ONE_CNT;
      end
    end else if (out_valid_q && out_ready) begin
      // Drained with nothing to replace it; data and lock hold for inspection.
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q         <= '0;
      fill_cnt_q   <= '0;
      out_bit_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_locked_q <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      fill_cnt_q   <= fill_cnt_d;
      out_bit_q    <= out_bit_d;
      out_valid_q  <= out_valid_d;
      out_locked_q <= out_locked_d;
    end
  end

  assign out_bit    = out_bit_q;
  assign out_valid  = out_valid_q;
  assign out_locked = out_locked_q;

endmodule

// File: tb/tb_self_sync_descrambler.sv
// Bench for self_sync_descrambler: scoreboard of expected beats pushed on input
// acceptance and popped on output handshake; a bench-side scrambler supplies
// the loopback stream.
module tb_self_sync_descrambler;

  localparam int unsigned ORDER = 7;
  localparam logic [6:0]  TAPS  = 7'b1100000;

  logic clk;
  logic rst;
  logic flush;
  logic in_bit;
  logic in_valid;
  logic in_ready;
  logic out_bit;
  logic out_valid;
  logic out_ready;
  logic out_locked;

  self_sync_descrambler #(
    .ORDER (ORDER),
    .TAPS  (TAPS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_bit     (in_bit),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_bit    (out_bit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_locked (out_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic chk;    // compare out_bit
    logic b;      // expected out_bit
    logic lock;   // expected out_locked
  } sb_item_t;

  sb_item_t   sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_out    = 0;
  int         acc_cnt  = 0;
  logic       acc_now  = 1'b0;
  logic       acc_prev = 1'b0;
  logic       mon_en   = 1'b0;
  logic       drv_exp  = 1'b0;
  logic       drv_chk  = 1'b0;
  logic [6:0] shist    = '0;   // bench scrambler history (its past outputs)
  int         rdy_mode = 1;    // 0: out_ready low, 1: high, 2: random

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // out_ready driver: the only writer of out_ready, updated 2 time units after each edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor / scoreboard, sampling on the falling edge.
  always @(negedge clk) begin
    sb_item_t it;
    acc_now = 1'b0;
    if (mon_en) begin
      check_eq("in_ready_rule", {31'd0, in_ready}, {31'd0, !flush && (!out_valid || out_ready)});
      if (acc_prev) check_eq("latency_1cyc", {31'd0, out_valid}, 32'd1);
      if (rst) begin
        sb.delete();
        acc_cnt = 0;
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check_eq("sb_underflow", sb.size(), 1);
          end else begin
            it = sb.pop_front();
            if (it.chk) check_eq("out_bit", {31'd0, out_bit}, {31'd0, it.b});
            check_eq("out_locked", {31'd0, out_locked}, {31'd0, it.lock});
            n_out++;
          end
        end
        if (flush) begin
          sb.delete();
          acc_cnt = 0;
        end else if (in_valid && in_ready) begin
          it.lock = (acc_cnt >= ORDER);
          it.chk  = drv_chk || it.lock;
          it.b    = drv_exp;
          sb.push_back(it);
          if (acc_cnt < ORDER) acc_cnt++;
          acc_now = 1'b1;
        end
      end
    end
    acc_prev = acc_now;
  end

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic b, input logic e, input logic ck, output int cyc, output logic ok);
    in_bit   = b;
    drv_exp  = e;
    drv_chk  = ck;
    in_valid = 1'b1;
    cyc      = 0;
    do begin
      @(posedge clk);
      cyc++;
    end while (!acc_now && cyc < 200);
    ok = acc_now;
    if (!acc_now) check_eq("accept_timeout", {31'd0, acc_now}, 32'd1);
    #1;
    in_valid = 1'b0;
  endtask

  // Loopback beat: scramble plaintext p with the bench scrambler, expect p back.
  task automatic lb_send(input logic p, input logic ck);
    logic s;
    int   cyc;
    logic ok;
    s = p ^ (^(shist & TAPS));
    send_beat(s, p, ck, cyc, ok);
    if (ok) shist = {shist[5:0], s};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    shist = '0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((sb.size() != 0 || out_valid) && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq(tag, sb.size(), 0);
  endtask

  initial begin
    int   cyc;
    logic ok;
    int   n0;
    logic p;
    logic held;
    rst      = 1'b1;
    flush    = 1'b0;
    in_bit   = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Reset state
    @(negedge clk);
    check_eq("rst_out_valid",  {31'd0, out_valid},  32'd0);
    check_eq("rst_out_bit",    {31'd0, out_bit},    32'd0);
    check_eq("rst_out_locked", {31'd0, out_locked}, 32'd0);
    check_eq("rst_in_ready",   {31'd0, in_ready},   32'd1);
    @(posedge clk);
    #1;

    // T1: zero stream, full throughput, lock on beat 8
    for (int i = 1; i <= 20; i++) begin
      send_beat(1'b0, 1'b0, 1'b1, cyc, ok);
      check_eq("t1_no_bubble", cyc, 1);
    end
    drain("t1_drain");

    // T2: single 1 at beat 10 -> output 1 at beats 10, 16, 17
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      send_beat(i == 10, (i == 10) || (i == 16) || (i == 17), 1'b1, cyc, ok);
    end
    drain("t2_drain");

    // T3: random loopback with random stalls on both sides
    do_reset();
    rdy_mode = 2;
    n0 = n_out;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      lb_send(1'($urandom_range(0, 1)), 1'b1);
    end
    rdy_mode = 1;
    drain("t3_drain");
    check_eq("t3_no_drops", n_out - n0, 1000);

    // T4: output stalled, input held off, nothing lost after release
    rdy_mode = 0;
    held = 1'($urandom_range(0, 1));
    lb_send(held, 1'b1);
    p = ~held;
    in_bit   = p ^ (^(shist & TAPS));
    drv_exp  = p;
    drv_chk  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t4_in_ready",  {31'd0, in_ready},  32'd0);
      check_eq("t4_out_valid", {31'd0, out_valid}, 32'd1);
      check_eq("t4_out_bit",   {31'd0, out_bit},   {31'd0, held});
      @(posedge clk);
      #1;
    end
    rdy_mode = 1;
    lb_send(p, 1'b1);
    for (int i = 0; i < 10; i++) lb_send(1'($urandom_range(0, 1)), 1'b1);
    drain("t4_drain");

    // T5: flush concurrent with a valid beat at beat 30
    do_reset();
    rdy_mode = 2;
    for (int i = 1; i <= 29; i++) lb_send(1'($urandom_range(0, 1)), 1'b1);
    flush    = 1'b1;
    in_bit   = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check_eq("t5_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("t5_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    // Descrambler history restarts from zero while the scrambler's does not:
    // bits are only compared once locked; lock itself is always compared.
    for (int i = 0; i < 20; i++) lb_send(1'($urandom_range(0, 1)), 1'b0);
    rdy_mode = 1;
    drain("t5_drain");

    // T6: reset (with flush) mid-stream while an output beat is pending
    rdy_mode = 0;
    lb_send(1'b1, 1'b0);
    @(negedge clk);
    check_eq("t6_pre_valid", {31'd0, out_valid}, 32'd1);
    check_eq("t6_pre_bit",   {31'd0, out_bit},   32'd1);
    @(posedge clk);
    #1;
    rst   = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    flush    = 1'b0;
    shist    = '0;
    rdy_mode = 1;
    @(negedge clk);
    check_eq("t6_out_valid",  {31'd0, out_valid},  32'd0);
    check_eq("t6_out_bit",    {31'd0, out_bit},    32'd0);
    check_eq("t6_out_locked", {31'd0, out_locked}, 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) lb_send(1'($urandom_range(0, 1)), 1'b1);
    drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
